elastic_pipeline: RTL and testbench

ELASTIC_PIPELINE -- requirements
Module: elastic_pipeline

---
 rtl/elastic_pipeline.sv | 170 +++++++++++++++++
 tb/tb_elastic_pipeline.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipeline.sv
// ---------------------------------------------------------------------------
// elastic_pipeline
//
// Purpose:
//   A DEPTH-stage valid/ready register pipeline with bubble collapsing.
//   Each stage holds one beat. A stage hands its beat on when the next stage
//   is empty or is emptying this edge. An empty stage always loads from its
//   predecessor, even while the output is stalled. The last stage drives
//   data_out/valid_out directly from its registers.
//
// Optional feature (macro ELASTIC_PIPELINE_SKID_EN):
//   Undefined (default): ready_out is combinational. It is derived from the
//     ready chain through all stages, so it depends on ready_in in the same
//     cycle. At most DEPTH beats are held.
//   Defined: a one-entry skid register sits in front of stage 0. ready_out
//     comes from a register that is high while the skid entry is empty. A
//     beat accepted while stage 0 cannot load is parked in the skid entry.
//     A parked beat drains into stage 0 before any new input. At most
//     DEPTH+1 beats are held.
//
// Ports:
//   clk_in     in   1                  clock, rising edge
//   rst_n_in   in   1                  asynchronous active-low reset
//   data_in    in   WIDTH              upstream beat payload
//   valid_in   in   1                  upstream beat present
//   ready_out  out  1                  block accepts a beat this cycle
//   data_out   out  WIDTH              payload of the last stage
//   valid_out  out  1                  last stage holds a beat
//   ready_in   in   1                  downstream accepts the beat this cycle
//   count_out  out  $clog2(DEPTH+2)    beats currently held (stages + skid)
// ---------------------------------------------------------------------------
module elastic_pipeline #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 16
) (
   input  logic                       clk_in,
   input  logic                       rst_n_in,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       valid_in,
   output logic                       ready_out,
   output logic [WIDTH-1:0]           data_out,
   output logic                       valid_out,
   input  logic                       ready_in,
   output logic [$clog2(DEPTH+2)-1:0] count_out
);

   localparam int CW = $clog2(DEPTH+2);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [DEPTH-1:0] vld_d;
   logic [DEPTH-1:0] open_v;     // stage i may take a new beat on this edge
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             accept;
   logic             emit;
   logic             s0_load;    // a beat is offered to stage 0
   logic [WIDTH-1:0] s0_src;     // payload offered to stage 0

   // Ready chain from the output back to stage 0. A stage is open when it
   // is empty or when everything downstream of it is moving. This reduces
   // to: open[i] = !vld[i] || open[i+1], where open[DEPTH] = ready_in.
   always_comb begin
      logic nxt_open;
      nxt_open = ready_in;
      open_v   = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         open_v[i] = ~vld_q[i] | nxt_open;
         nxt_open  = open_v[i];
      end
   end

   assign emit = vld_q[DEPTH-1] & ready_in;

`ifdef ELASTIC_PIPELINE_SKID_EN
   logic [WIDTH-1:0] skid_data_q;
   logic [WIDTH-1:0] skid_data_d;
   logic             skid_vld_q;
   logic             skid_vld_d;
   logic             rdy_q;
   logic             rdy_d;

   // rdy_q resets high so that the first edge after reset release can
   // accept. The reset gate keeps ready_out low while reset is asserted.
   assign ready_out = rst_n_in & rdy_q;
   assign accept    = valid_in & ready_out;

   always_comb begin
      s0_load     = accept;
      s0_src      = data_in;
      skid_vld_d  = skid_vld_q;
      skid_data_d = skid_data_q;
      if (skid_vld_q) begin
         // A parked beat goes to stage 0 first. No new beat is accepted
         // while it waits, because ready_out is low.
         s0_load    = 1'b1;
         s0_src     = skid_data_q;
         skid_vld_d = ~open_v[0];
      end else if (accept && !open_v[0]) begin
         skid_vld_d  = 1'b1;
         skid_data_d = data_in;
      end
      rdy_d = ~skid_vld_d;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         skid_vld_q  <= 1'b0;
         skid_data_q <= '0;
         rdy_q       <= 1'b1;
      end else begin
         skid_vld_q  <= skid_vld_d;
         skid_data_q <= skid_data_d;
         rdy_q       <= rdy_d;
      end
   end
`else
   assign ready_out = rst_n_in & open_v[0];
   assign accept    = valid_in & ready_out;
   assign s0_load   = accept;
   assign s0_src    = data_in;
`endif

   // Stage next-state. Data registers change only on a load, so empty
   // stages keep their stale payload rather than toggling.
   always_comb begin
      vld_d = vld_q;
      for (int i = 0; i < DEPTH; i++) begin
         data_d[i] = data_q[i];
      end
      if (open_v[0]) begin
         vld_d[0] = s0_load;
         if (s0_load) begin
            data_d[0] = s0_src;
         end
      end
      for (int i = 1; i < DEPTH; i++) begin
         if (open_v[i]) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) begin
               data_d[i] = data_q[i-1];
            end
         end
      end
   end

   assign count_d = count_q + CW'(accept) - CW'(emit);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         vld_q   <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         vld_q   <= vld_d;
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   assign data_out  = data_q[DEPTH-1];
   assign valid_out = vld_q[DEPTH-1];
   assign count_out = count_q;

endmodule

// File: tb/tb_elastic_pipeline.sv
// ---------------------------------------------------------------------------
// tb_elastic_pipeline
//
// Scoreboard bench for elastic_pipeline. The reference model is a FIFO of
// accepted beats. An input recorder pushes every beat accepted on an
// upstream handshake. An output monitor pops and compares on every
// downstream handshake. The held-beat count must equal the model's
// occupancy after every edge. Directed scenarios cover reset, streaming,
// stall, unstall, bubble collapse and mid-stream reset. A long random run
// follows them. Define ELASTIC_PIPELINE_SKID_EN to build against the
// skid-buffer variant.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_elastic_pipeline;

   localparam int DEPTH = 2;
   localparam int WIDTH = 16;
   localparam int CW    = $clog2(DEPTH+2);
`ifdef ELASTIC_PIPELINE_SKID_EN
   localparam int SKID  = 1;
`else
   localparam int SKID  = 0;
`endif
   localparam int CAP   = DEPTH + SKID;

   logic             clk_in = 1'b0;
   logic             rst_n_in;
   logic [WIDTH-1:0] data_in;
   logic             valid_in;
   logic             ready_out;
   logic [WIDTH-1:0] data_out;
   logic             valid_out;
   logic             ready_in;
   logic [CW-1:0]    count_out;

   int               errors = 0;
   int               checks = 0;
   int               n_acc  = 0;
   logic [WIDTH-1:0] exp_q [$];
   logic             stall_prev = 1'b0;
   logic [WIDTH-1:0] data_prev  = '0;

   always #5 clk_in = ~clk_in;

   elastic_pipeline #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .data_out  (data_out),
      .valid_out (valid_out),
      .ready_in  (ready_in),
      .count_out (count_out)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Inputs change 1ns after a rising edge. Values seen on the falling edge
   // are therefore the values present at the next rising edge.
   initial forever begin
      @(negedge clk_in);
      if (rst_n_in && valid_in && ready_out) begin
         exp_q.push_back(data_in);
         n_acc++;
      end
   end

   initial forever begin
      @(negedge clk_in);
      if (!rst_n_in) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", valid_out, 1);
            check("hold_data", data_out, data_prev);
         end
         if (valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got %0h, expected no beat", data_out);
            end else begin
               check("beat_data", data_out, exp_q.pop_front());
            end
         end
         stall_prev = valid_out && !ready_in;
         data_prev  = data_out;
      end
   end

   // The held count must equal the model occupancy after every edge.
   initial forever begin
      @(posedge clk_in);
      #2;
      if (rst_n_in) begin
         check("count_vs_model", count_out, exp_q.size());
      end
   end

   // Offer one beat and hold it until accepted. The task returns 1ns after
   // the accepting edge.
   task automatic push(input logic [WIDTH-1:0] d);
      int   n;
      logic acc;
      n        = 0;
      acc      = 1'b0;
      valid_in = 1'b1;
      data_in  = d;
      while (!acc && n < 50) begin
         #1;
         acc = ready_out;
         @(posedge clk_in);
         #1;
         n++;
      end
      valid_in = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: beat %0h not accepted, got %0d cycles, expected < 50", d, n);
      end
   endtask

   task automatic drain();
      int n;
      n        = 0;
      valid_in = 1'b0;
      ready_in = 1'b1;
      while (count_out != 0 && n < 50) begin
         @(posedge clk_in);
         #1;
         n++;
      end
      check("drain_count", count_out, 0);
      check("drain_valid", valid_out, 0);
   endtask

   initial begin
      int       target;
      int       cyc;
      logic     exp_unstall_rdy;
      logic     exp_full_rdy;

      exp_unstall_rdy = (SKID == 0);
      exp_full_rdy    = (SKID != 0) || (DEPTH > 2);

      rst_n_in = 1'b0;
      valid_in = 1'b0;
      ready_in = 1'b0;
      data_in  = '0;
      #3;
      check("rst_valid_out", valid_out, 0);
      check("rst_data_out", data_out, 0);
      check("rst_count_out", count_out, 0);
      check("rst_ready_out", ready_out, 0);
      @(posedge clk_in);
      #1;
      @(posedge clk_in);
      #1;
      rst_n_in = 1'b1;

      // Unstalled stream: latency of DEPTH edges, then one beat per cycle.
      ready_in = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         valid_in = 1'b1;
         data_in  = WIDTH'(i);
         @(posedge clk_in);
         #1;
         if (i == DEPTH - 1) check("stream_lat_early", valid_out, 0);
         if (i == DEPTH) begin
            check("stream_lat_valid", valid_out, 1);
            check("stream_lat_data", data_out, 1);
         end
      end
      valid_in = 1'b0;
      check("stream_count_steady", count_out, DEPTH);
      drain();

      // Full stall.
      ready_in = 1'b0;
      push(16'hAAAA);
      push(16'hBBBB);
`ifdef ELASTIC_PIPELINE_SKID_EN
      push(16'hCCCC);
`endif
      valid_in = 1'b1;
      data_in  = 16'h1234;
      #1;
      check("full_ready_out", ready_out, 0);
      check("full_count", count_out, CAP);
      check("full_valid_out", valid_out, 1);
      check("full_data_out", data_out, 16'hAAAA);
      repeat (2) begin
         @(posedge clk_in);
         #1;
      end
      check("stall_data_held", data_out, 16'hAAAA);
      check("stall_count_held", count_out, CAP);

      // One unstall cycle while a beat is offered.
      ready_in = 1'b1;
      #1;
      check("unstall_ready_out", ready_out, exp_unstall_rdy);
      @(posedge clk_in);
      #1;
      ready_in = 1'b0;
      valid_in = 1'b0;
      check("unstall_count", count_out, DEPTH);
      check("unstall_data_next", data_out, 16'hBBBB);
      drain();

      // Bubble collapse under a downstream stall.
      ready_in = 1'b0;
      push(16'h0011);
      repeat (3) begin
         @(posedge clk_in);
         #1;
      end
      push(16'h0022);
      check("bubble_count", count_out, 2);
      check("bubble_valid_out", valid_out, 1);
      check("bubble_data_out", data_out, 16'h0011);
      check("bubble_ready_out", ready_out, exp_full_rdy);
      ready_in = 1'b1;
      @(posedge clk_in);
      #1;
      check("bubble_no_gap_valid", valid_out, 1);
      check("bubble_no_gap_data", data_out, 16'h0022);
      drain();

      // Reset mid-stream, asserted between edges.
      ready_in = 1'b0;
      push(16'h0101);
      push(16'h0202);
      check("pre_reset_count", count_out, 2);
      rst_n_in   = 1'b0;
      exp_q.delete();
      stall_prev = 1'b0;
      #1;
      check("async_rst_valid_out", valid_out, 0);
      check("async_rst_count_out", count_out, 0);
      check("async_rst_data_out", data_out, 0);
      check("async_rst_ready_out", ready_out, 0);
      #2;
      valid_in = 1'b1;
      data_in  = 16'h5555;
      ready_in = 1'b1;
      rst_n_in = 1'b1;
      @(posedge clk_in);
      #1;
      valid_in = 1'b0;
      for (int e = 1; e < DEPTH; e++) begin
         check("post_rst_lat_early", valid_out, 0);
         @(posedge clk_in);
         #1;
      end
      check("post_rst_valid", valid_out, 1);
      check("post_rst_data", data_out, 16'h5555);
      drain();

      // Random traffic.
      target = n_acc + 10000;
      cyc    = 0;
      while (n_acc < target && cyc < 60000) begin
         valid_in = ($urandom_range(0, 3) != 0);
         data_in  = WIDTH'($urandom);
         ready_in = ($urandom_range(0, 3) != 0);
         @(posedge clk_in);
         #1;
         cyc++;
      end
      if (n_acc < target) begin
         checks++;
         errors++;
         $display("FAIL random_timeout: got %0d accepts, expected %0d", n_acc, target);
      end
      drain();
      check("final_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
